comet_ii_fetch_sequencer: RTL



---
 rtl/comet_ii_pkg.sv | 38 +++
 rtl/comet_ii_ilen_decode.sv | 11 +
 rtl/comet_ii_fetch_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/comet_ii_pkg.sv
// Shared definitions for the COMET II fetch path: machine-state encodings,
// opcode constants and the instruction-length rule.
package comet_ii_pkg;

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_INIT  = 3'b001;
    localparam logic [2:0] ST_IFET1 = 3'b010;
    localparam logic [2:0] ST_IFET2 = 3'b011;
    localparam logic [2:0] ST_EXEC  = 3'b100;

    localparam logic [15:0] START_ADDR_DEFAULT = 16'h0000;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_PUSH = 8'h70;
    localparam logic [7:0] OP_POP  = 8'h71;
    localparam logic [7:0] OP_CALL = 8'h80;
    localparam logic [7:0] OP_RET  = 8'h81;
    localparam logic [7:0] OP_SVC  = 8'hF0;

    // Memory/address forms carry a second word; register forms (x4-x7),
    // POP, RET and every undefined code are single-word.
    function automatic logic is_two_word(input logic [7:0] op);
        logic two;
        two = 1'b0;
        case (op)
            8'h10, 8'h11, 8'h12:                            two = 1'b1;
            8'h20, 8'h21, 8'h22, 8'h23:                     two = 1'b1;
            8'h30, 8'h31, 8'h32:                            two = 1'b1;
            8'h40, 8'h41:                                   two = 1'b1;
            8'h50, 8'h51, 8'h52, 8'h53:                     two = 1'b1;
            8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66:       two = 1'b1;
            OP_PUSH, OP_CALL, OP_SVC:                       two = 1'b1;
            default:                                        two = 1'b0;
        endcase
        return two;
    endfunction

endpackage

// File: rtl/comet_ii_ilen_decode.sv
// Combinational opcode -> two-word flag, shared with the instruction decoder.
module comet_ii_ilen_decode
    import comet_ii_pkg::*;
(
    input  logic [7:0] op,
    output logic       two_word
);

    assign two_word = is_two_word(op);

endmodule

// File: rtl/comet_ii_fetch_sequencer.sv
// COMET II fetch/cycle sequencer: owns PR, the instruction register, the
// second instruction word and the IDLE/INIT/IFET1/IFET2/EXEC machine state.
module comet_ii_fetch_sequencer
    import comet_ii_pkg::*;
#(
    parameter logic [15:0] START_ADDR = START_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [2:0]  state,
    output logic [7:0]  op_code,
    output logic [7:0]  regs,
    output logic [15:0] adr,
    output logic        adr_en,
    input  logic        jump,
    input  logic        call,
    input  logic        ret,
    input  logic [15:0] eff_adr,
    input  logic [15:0] ret_adr,
    output logic [15:0] pr,
    output logic [31:0] inst_count
);

    logic two_word;

    comet_ii_ilen_decode u_ilen (
        .op       (mem_rdata[15:8]),
        .two_word (two_word)
    );

    // Memory handshake: mem_req is held high through every IFET cycle until
    // mem_ack; a word transfers on the rising edge where both are high, and
    // mem_ack is ignored whenever mem_req is low.
    assign mem_req  = (state == ST_IFET1) || (state == ST_IFET2);
    assign mem_addr = pr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pr         <= 16'h0000;
            op_code    <= 8'h00;
            regs       <= 8'h00;
            adr        <= 16'h0000;
            adr_en     <= 1'b0;
            inst_count <= 32'h0000_0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    pr    <= START_ADDR;
                    state <= ST_IFET1;
                end
                ST_IFET1: begin
                    if (mem_ack) begin
                        op_code <= mem_rdata[15:8];
                        regs    <= mem_rdata[7:0];
                        pr      <= pr + 16'h0001;
                        adr_en  <= two_word;
                        adr     <= 16'h0000;
                        state   <= two_word ? ST_IFET2 : ST_EXEC;
                    end
                end
                ST_IFET2: begin
                    if (mem_ack) begin
                        adr   <= mem_rdata;
                        pr    <= pr + 16'h0001;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    inst_count <= inst_count + 32'h0000_0001;
                    // Redirects from the decoder take effect only here.
                    if (jump || call) begin
                        pr <= eff_adr;
                    end else if (ret) begin
                        pr <= ret_adr;
                    end
                    state <= halt_req ? ST_IDLE : ST_IFET1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
